// File: rtl/jtdd_prog_sdram.sv
// ROM download to SDRAM write buffer: a small FIFO feeding a request/ack writer FSM.
// Optional JTDD_PROG_CHECKSUM_EN adds a 16-bit running sum of the acknowledged bytes.
module jtdd_prog_sdram #(
  parameter int DW_FIFO = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_wrmask,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        overflow,
  output logic        loaded
`ifdef JTDD_PROG_CHECKSUM_EN
  ,output logic [15:0] checksum
`endif
);

  localparam int DEPTH = 1 << DW_FIFO;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state;
  logic [31:0]        mem [DEPTH];
  logic [DW_FIFO-1:0] wr_ptr, rd_ptr;
  logic [DW_FIFO:0]   count;
  logic               pop, full, push_ok, dl_q, dl_rise, started, head_valid;

  assign pop     = (state == REQ) && sdram_ack;
  assign full    = count == (DW_FIFO+1)'(DEPTH);
  assign push_ok = prog_we && (!full || pop);
  assign dl_rise = downloading && !dl_q;

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= {prog_addr, prog_data, prog_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_din    <= '0;
      sdram_wrmask <= 2'b11;
      overflow     <= 1'b0;
      loaded       <= 1'b0;
      dl_q         <= 1'b0;
      started      <= 1'b0;
      head_valid   <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (downloading) started <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          // head is latched one cycle before the request so outputs are stable when req rises
          if (head_valid) begin
            state      <= REQ;
            sdram_req  <= 1'b1;
            head_valid <= 1'b0;
          end else if (count != '0) begin
            sdram_addr   <= mem[rd_ptr][31:10];
            sdram_din    <= {mem[rd_ptr][9:2], mem[rd_ptr][9:2]};
            sdram_wrmask <= mem[rd_ptr][1:0];
            head_valid   <= 1'b1;
          end else if (!downloading && started) begin
            state  <= DONE;
            loaded <= 1'b1;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= IDLE;
          end
        end
        DONE: begin
          if (dl_rise) begin
            state    <= IDLE;
            loaded   <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (prog_we && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef JTDD_PROG_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || dl_rise) checksum <= '0;
    else if (pop)       checksum <= checksum + {8'd0, sdram_din[7:0]};
  end
`endif

endmodule

// File: tb/tb_jtdd_prog_sdram.sv
// Directed bench for jtdd_prog_sdram; checksum test is compiled in with JTDD_PROG_CHECKSUM_EN.
module tb_jtdd_prog_sdram;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [1:0]  prog_mask = 2'b11;
  logic        prog_we = 1'b0;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_wrmask;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        overflow;
  logic        loaded;
`ifdef JTDD_PROG_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  jtdd_prog_sdram #(.DW_FIFO(2)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_wrmask(sdram_wrmask),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .overflow(overflow), .loaded(loaded)
`ifdef JTDD_PROG_CHECKSUM_EN
    ,.checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && sdram_req && sdram_ack) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; prog_we = 1'b0; sdram_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    prog_addr = a; prog_data = d; prog_mask = m; prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic ack_one(output bit ok);
    wait_req(ok);
    if (ok) begin
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", sdram_req); end
    tests++; if (sdram_addr !== 22'd0) begin fails++; $display("FAIL rst_addr got %h want 0", sdram_addr); end
    tests++; if (sdram_din !== 16'd0) begin fails++; $display("FAIL rst_din got %h want 0", sdram_din); end
    tests++; if (sdram_wrmask !== 2'b11) begin fails++; $display("FAIL rst_mask got %b want 11", sdram_wrmask); end
    tests++; if (overflow !== 1'b0 || loaded !== 1'b0) begin fails++; $display("FAIL rst_flags got ovf=%b ld=%b want 0 0", overflow, loaded); end
  endtask

  task automatic test_single();
    int base;
    downloading = 1'b1;
    tick();
    base = wr_cnt;
    prog_addr = 22'h20000; prog_data = 8'hA5; prog_mask = 2'b10; prog_we = 1'b1;
    tick();                          // edge N
    prog_we = 1'b0; sdram_ack = 1'b1; // stray ack while idle
    tests++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL single_req_n got %b want 0", sdram_req); end
    tick();                          // edge N+1
    sdram_ack = 1'b0;
    tests++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL single_req_n1 got %b want 0", sdram_req); end
    tick();                          // edge N+2
    tests++; if (sdram_req !== 1'b1) begin fails++; $display("FAIL single_req_n2 got %b want 1", sdram_req); end
    tests++; if (sdram_addr !== 22'h20000) begin fails++; $display("FAIL single_addr got %h want 20000", sdram_addr); end
    tests++; if (sdram_din !== 16'hA5A5) begin fails++; $display("FAIL single_din got %h want a5a5", sdram_din); end
    tests++; if (sdram_wrmask !== 2'b10) begin fails++; $display("FAIL single_mask got %b want 10", sdram_wrmask); end
    tick(); tick();
    tests++; if (sdram_req !== 1'b1) begin fails++; $display("FAIL single_hold got %b want 1", sdram_req); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tests++; if (sdram_req !== 1'b0) begin fails++; $display("FAIL single_drop got %b want 0", sdram_req); end
    repeat (4) tick();
    tests++; if (wr_cnt - base !== 1 || sdram_req !== 1'b0) begin fails++; $display("FAIL single_count got %0d req=%b want 1 0", wr_cnt - base, sdram_req); end
  endtask

  task automatic test_burst();
    int base;
    bit ok;
    logic [21:0] exp_addr [4];
    base = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      prog_addr = 22'h100 + 22'(i); prog_data = 8'(8'h10 + i); prog_mask = 2'b01; prog_we = 1'b1;
      tick();
    end
    prog_we = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL burst_ovf got %b want 1", overflow); end
    tests++; if (dut.count !== 3'd4) begin fails++; $display("FAIL burst_count got %0d want 4", dut.count); end
    exp_addr[0] = 22'h100; exp_addr[1] = 22'h101; exp_addr[2] = 22'h102; exp_addr[3] = 22'h103;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      tests++; if (!ok || sdram_addr !== exp_addr[i]) begin fails++; $display("FAIL burst_addr%0d got %h ok=%b want %h", i, sdram_addr, ok, exp_addr[i]); end
      sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    end
    repeat (6) tick();
    tests++; if (wr_cnt - base !== 4 || sdram_req !== 1'b0) begin fails++; $display("FAIL burst_writes got %0d req=%b want 4 0", wr_cnt - base, sdram_req); end
  endtask

  task automatic test_full_pushpop();
    int base;
    bit ok;
    do_reset();
    downloading = 1'b1;
    base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      prog_addr = 22'h200 + 22'(i); prog_data = 8'(i); prog_mask = 2'b00; prog_we = 1'b1;
      tick();
    end
    prog_we = 1'b0;
    tests++; if (dut.count !== 3'd4 || sdram_req !== 1'b1) begin fails++; $display("FAIL full_pre got cnt=%0d req=%b want 4 1", dut.count, sdram_req); end
    prog_addr = 22'h204; prog_data = 8'h44; prog_we = 1'b1; sdram_ack = 1'b1;
    tick();
    prog_we = 1'b0; sdram_ack = 1'b0;
    tests++; if (dut.count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", dut.count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      if (i == 3) begin
        tests++; if (!ok || sdram_addr !== 22'h204) begin fails++; $display("FAIL full_last_addr got %h want 204", sdram_addr); end
      end
      if (ok) begin sdram_ack = 1'b1; tick(); sdram_ack = 1'b0; end
    end
    repeat (6) tick();
    tests++; if (wr_cnt - base !== 5) begin fails++; $display("FAIL full_writes got %0d want 5", wr_cnt - base); end
  endtask

  task automatic test_loaded();
    bit ok;
    for (int i = 0; i < 3; i++) push(22'h300 + 22'(i), 8'(i), 2'b00);
    downloading = 1'b0;
    tick();
    tests++; if (loaded !== 1'b0) begin fails++; $display("FAIL loaded_pending got %b want 0", loaded); end
    for (int i = 0; i < 3; i++) begin
      ack_one(ok);
      tests++; if (!ok || loaded !== 1'b0) begin fails++; $display("FAIL loaded_ack%0d got ld=%b ok=%b want 0 1", i, loaded, ok); end
    end
    tick();
    tests++; if (loaded !== 1'b1) begin fails++; $display("FAIL loaded_set got %b want 1", loaded); end
    repeat (3) tick();
    tests++; if (loaded !== 1'b1) begin fails++; $display("FAIL loaded_hold got %b want 1", loaded); end
    downloading = 1'b1;
    tick();
    tests++; if (loaded !== 1'b0) begin fails++; $display("FAIL loaded_clear got %b want 0", loaded); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    bit seen;
    push(22'h3FFFFF, 8'h5A, 2'b00);
    push(22'h000001, 8'h5B, 2'b00);
    wait_req(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_req got 0 want 1"); end
    rst = 1'b1; sdram_ack = 1'b1;
    tick();
    rst = 1'b0; sdram_ack = 1'b0;
    tests++; if (sdram_req !== 1'b0 || dut.count !== 3'd0) begin fails++; $display("FAIL rstmid_clear got req=%b cnt=%0d want 0 0", sdram_req, dut.count); end
    seen = 1'b0;
    repeat (8) begin tick(); if (sdram_req) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_quiet got req seen=%b want 0", seen); end
  endtask

`ifdef JTDD_PROG_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    do_reset();
    downloading = 1'b1;
    tick();
    push(22'h10, 8'hFF, 2'b10);
    push(22'h11, 8'h02, 2'b01);
    push(22'h12, 8'h01, 2'b10);
    for (int i = 0; i < 3; i++) ack_one(ok);
    tick();
    tests++; if (checksum !== 16'h0102) begin fails++; $display("FAIL checksum got %h want 0102", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_pushpop();
    test_loaded();
    test_rst_mid();
`ifdef JTDD_PROG_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
